branch_redirect_unit: RTL and testbench

Owns the fetch PC and turns the ID-stage branch decision (`brCond` from the condition checker) into a PC redirect plus an IF/ID flush. It sits between the condition checker in ID and the instruction-memory address port in IF. It computes branch and jump targets, holds a resolved redirect across hazard stalls, and counts taken redirects for performance monitoring.

---
 rtl/branch_redirect_unit_pkg.sv | 25 ++
 rtl/branch_redirect_unit_if.sv | 30 +++
 rtl/branch_redirect_unit_target_calc.sv | 27 ++
 rtl/branch_redirect_unit.sv | 88 ++++++++
 tb/tb_branch_redirect_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/branch_redirect_unit_pkg.sv
// Shared encodings for the ID-stage branch path: branch classes used by the
// condition checker and the redirect unit, the default reset fetch address,
// and the redirect unit's state encoding.
package branch_redirect_unit_pkg;

  typedef enum logic [1:0] {
    COND_NONE = 2'd0,
    COND_JUMP = 2'd1,
    COND_BEZ  = 2'd2,
    COND_BNE  = 2'd3
  } cond_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_PENDING = 1'b1
  } bru_state_e;

  // True for the branch classes that may redirect fetch.
  function automatic logic is_branch(input logic [1:0] comm);
    return (comm == COND_JUMP) || (comm == COND_BEZ) || (comm == COND_BNE);
  endfunction

endpackage

// File: rtl/branch_redirect_unit_if.sv
// ID-stage decision inputs and IF-stage fetch outputs of the redirect unit.
interface branch_redirect_unit_if #(
  parameter int CNT_W = 16
) ();

  logic             freeze;
  logic             idValid;
  logic             brCond;
  logic [1:0]       cuBranchComm;
  logic [31:0]      pcId;
  logic [31:0]      immExt;
  logic [25:0]      jumpAddr;
  logic [31:0]      pc;
  logic             flushIfId;
  logic             redirectPending;
  logic [CNT_W-1:0] takenCount;

  // Pipeline / hazard side: drives the decision, consumes the fetch address.
  modport master (
    output freeze, idValid, brCond, cuBranchComm, pcId, immExt, jumpAddr,
    input  pc, flushIfId, redirectPending, takenCount
  );

  // Redirect unit side.
  modport slave (
    input  freeze, idValid, brCond, cuBranchComm, pcId, immExt, jumpAddr,
    output pc, flushIfId, redirectPending, takenCount
  );

endinterface

// File: rtl/branch_redirect_unit_target_calc.sv
// Branch / jump target computation for the instruction currently in ID.
module branch_target_calc
  import branch_redirect_unit_pkg::*;
(
  input  logic [31:0] pcId,
  input  logic [31:0] immExt,
  input  logic [25:0] jumpAddr,
  input  logic [1:0]  cuBranchComm,
  output logic [31:0] target
);

  logic signed [31:0] offset_s;

  // Jumps splice the field into the current 256 MB region; conditional
  // branches add the word offset to PC+4 with modular wrap.
  always_comb begin
    offset_s = $signed(immExt) <<< 2;
    target   = pcId;
    case (cuBranchComm)
      COND_JUMP: target = {pcId[31:28], jumpAddr, 2'b00};
      COND_BEZ,
      COND_BNE:  target = pcId + $unsigned(offset_s);
      default:   target = pcId;
    endcase
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// Fetch PC owner: applies taken ID-stage branches as PC redirects with an
// IF/ID flush, parks a redirect while the pipeline is frozen, and counts
// applied redirects.
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_redirect_unit_if.slave bus
);

  bru_state_e       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_target_q, pend_target_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;
  logic             flush;
  logic             accept;
  logic [31:0]      target;

  branch_target_calc u_target (
    .pcId         (bus.pcId),
    .immExt       (bus.immExt),
    .jumpAddr     (bus.jumpAddr),
    .cuBranchComm (bus.cuBranchComm),
    .target       (target)
  );

  // Next-state decode: redirect now, park the redirect under a stall,
  // release a parked redirect, or fall through sequentially.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    taken_count_d = taken_count_q;
    flush         = 1'b0;
    accept        = bus.idValid & bus.brCond & is_branch(bus.cuBranchComm)
                    & (state_q == ST_RUN);
    case (state_q)
      ST_RUN: begin
        if (accept && !bus.freeze) begin
          pc_d          = target;
          flush         = 1'b1;
          taken_count_d = taken_count_q + 1'b1;
        end else if (accept) begin
          // First decision wins; later operand changes during the stall
          // are ignored.
          pend_target_d = target;
          state_d       = ST_PENDING;
        end else if (!bus.freeze) begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_PENDING: begin
        if (!bus.freeze) begin
          pc_d          = pend_target_q;
          flush         = 1'b1;
          taken_count_d = taken_count_q + 1'b1;
          state_d       = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, fetch PC, parked target and counter; reset drops any parked redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= 32'h0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign bus.pc              = pc_q;
  assign bus.flushIfId       = flush & ~rst;
  assign bus.redirectPending = (state_q == ST_PENDING) & ~rst;
  assign bus.takenCount      = taken_count_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Randomized and directed checks of branch_redirect_unit against a
// cycle-level reference model of the redirect rules.
module tb_branch_redirect_unit;
  import branch_redirect_unit_pkg::*;

  localparam int          CNT_W = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  branch_redirect_unit_if #(.CNT_W(CNT_W)) bus ();

  branch_redirect_unit #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_ptgt;
  int          m_cnt;
  logic        m_last_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic frz, input logic bc, input logic v,
                        input logic [1:0] cu, input logic [31:0] pcid,
                        input logic [31:0] imm, input logic [25:0] ja);
    rst              = r;
    bus.freeze       = frz;
    bus.brCond       = bc;
    bus.idValid      = v;
    bus.cuBranchComm = cu;
    bus.pcId         = pcid;
    bus.immExt       = imm;
    bus.jumpAddr     = ja;
  endtask

  // One clock: predict from current inputs, check combinational outputs
  // before the edge and registered outputs after it.
  task automatic step();
    logic        e_flush;
    logic [31:0] tgt;
    logic [31:0] n_pc;
    logic        n_pend;
    logic [31:0] n_ptgt;
    int          n_cnt;
    logic        acc;
    e_flush = 1'b0;
    n_pc = m_pc; n_pend = m_pend; n_ptgt = m_ptgt; n_cnt = m_cnt;
    if (bus.cuBranchComm == COND_JUMP)
      tgt = {bus.pcId[31:28], bus.jumpAddr, 2'b00};
    else
      tgt = bus.pcId + bus.immExt * 4;
    acc = bus.idValid && bus.brCond && (bus.cuBranchComm != COND_NONE) && !m_pend;
    if (rst) begin
      n_pc = RST_PC; n_pend = 1'b0; n_ptgt = 32'h0; n_cnt = 0;
    end else if (m_pend) begin
      if (!bus.freeze) begin
        n_pc = m_ptgt; e_flush = 1'b1; n_pend = 1'b0; n_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
    end else if (acc && !bus.freeze) begin
      n_pc = tgt; e_flush = 1'b1; n_cnt = (m_cnt + 1) % (1 << CNT_W);
    end else if (acc) begin
      n_pend = 1'b1; n_ptgt = tgt;
    end else if (!bus.freeze) begin
      n_pc = m_pc + 32'd4;
    end
    #1;
    check("flushIfId", {31'b0, bus.flushIfId}, {31'b0, e_flush});
    check("pend_pre", {31'b0, bus.redirectPending}, {31'b0, m_pend && !rst});
    @(posedge clk);
    #1;
    m_pc = n_pc; m_pend = n_pend; m_ptgt = n_ptgt; m_cnt = n_cnt;
    m_last_flush = e_flush;
    check("pc", bus.pc, m_pc);
    check("pend", {31'b0, bus.redirectPending}, {31'b0, m_pend});
    check("takenCount", {28'b0, bus.takenCount}, m_cnt[31:0]);
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    m_pc = 32'hx; m_pend = 1'b0; m_ptgt = 32'h0; m_cnt = 0; m_last_flush = 1'b0;
    set_in(1, 0, 0, 0, COND_NONE, 0, 0, 0);
    @(posedge clk); #1;
    m_pc = RST_PC;

    // Reset, then free-running fetch
    set_in(1, 0, 0, 0, COND_NONE, 0, 0, 0);
    step();
    check("rst_pc", bus.pc, 32'h0);
    check("rst_cnt", {28'b0, bus.takenCount}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, COND_NONE, 0, 0, 0);
      step();
    end
    check("run_pc16", bus.pc, 32'h10);

    // Taken BEZ, no stall
    set_in(0, 0, 1, 1, COND_BEZ, 32'h104, 32'hFFFF_FFFE, 0);
    step();
    check("bez_pc", bus.pc, 32'hFC);
    check("bez_cnt", {28'b0, bus.takenCount}, 32'h1);

    // Bubble after redirect: brCond with idValid low is ignored
    set_in(0, 0, 1, 0, COND_BEZ, 32'h104, 32'hFFFF_FFFE, 0);
    step();
    check("bubble_pc", bus.pc, 32'h100);

    // Jump
    set_in(0, 0, 1, 1, COND_JUMP, 32'h3000_0010, 0, 26'h000_0040);
    step();
    check("jump_pc", bus.pc, 32'h3000_0100);
    set_in(0, 0, 0, 0, COND_NONE, 0, 0, 0);
    step();

    // Branch under a 3-cycle stall; operands change during the stall
    set_in(0, 1, 1, 1, COND_BNE, 32'h100, 32'h40, 0);
    step();
    check("stall_pc_hold", bus.pc, 32'h3000_0104);
    set_in(0, 1, 0, 1, COND_JUMP, 32'h5555_0000, 32'h7, 26'h3FF_FFFF);
    step();
    set_in(0, 1, 1, 1, COND_BEZ, 32'h9000_0000, 32'h123, 26'h1);
    step();
    check("stall_pend", {31'b0, bus.redirectPending}, 32'h1);
    set_in(0, 0, 0, 1, COND_NONE, 32'h0, 32'h0, 0);
    step();
    check("stall_release_pc", bus.pc, 32'h200);
    set_in(0, 0, 0, 0, COND_NONE, 0, 0, 0);
    step();

    // Reset mid-stall discards the parked redirect
    set_in(0, 1, 1, 1, COND_BNE, 32'h100, 32'h40, 0);
    step();
    set_in(1, 1, 0, 0, COND_NONE, 0, 0, 0);
    step();
    check("rstmid_pend", {31'b0, bus.redirectPending}, 32'h0);
    check("rstmid_cnt", {28'b0, bus.takenCount}, 32'h0);
    set_in(0, 0, 0, 0, COND_NONE, 0, 0, 0);
    step();
    check("rstmid_nored", bus.pc, RST_PC + 32'd4);

    // Randomized traffic; ID holds a bubble after every flush
    for (int i = 0; i < 400; i++) begin
      logic r, frz, v, bc;
      logic [1:0]  cu;
      logic [31:0] imm;
      r   = ($urandom_range(0, 99) < 2);
      frz = ($urandom_range(0, 9) < 4);
      v   = m_last_flush ? 1'b0 : ($urandom_range(0, 9) < 8);
      bc  = ($urandom_range(0, 9) < 5);
      cu  = 2'($urandom_range(0, 3));
      imm = {{16{1'b0}}, 16'($urandom)};
      if (imm[15]) imm[31:16] = 16'hFFFF;
      set_in(r, frz, bc, v, cu, $urandom, imm, 26'($urandom));
      step();
    end

    // Counter wrap: 17 redirects on a 4-bit counter
    set_in(1, 0, 0, 0, COND_NONE, 0, 0, 0);
    step();
    for (int i = 0; i < 17; i++) begin
      set_in(0, 0, 1, 1, COND_BEZ, 32'h100, 32'h1, 0);
      step();
      set_in(0, 0, 1, 0, COND_BEZ, 32'h100, 32'h1, 0);
      step();
    end
    check("wrap_cnt", {28'b0, bus.takenCount}, 32'h1);
    check("wrap_pc", bus.pc, 32'h108);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
